// File: rtl/control_unit_p.sv
// Multi-cycle control unit FSM: decodes IR[15:12] and drives datapath strobes combinationally from state and IR.
// Optional feature: define CU_JUMP_EN to enable the JPZ (jump if register zero) instruction.
module control_unit_p #(
    parameter int unsigned D_AW     = 8,
    parameter int unsigned ALU_W    = 3,
    parameter int unsigned ALU_ADD  = 1,
    parameter int unsigned ALU_SUB  = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      IR,
    input  logic             resume,
    input  logic             RF_Rp_zero,
    output logic             IR_ld,
    output logic             PC_clr,
    output logic             PC_up,
    output logic             PC_ld,
    output logic [7:0]       PC_addr,
    output logic [D_AW-1:0]  D_addr,
    output logic             D_wr,
    output logic [1:0]       RF_s,
    output logic [7:0]       RF_imm,
    output logic [3:0]       RF_W_addr,
    output logic [3:0]       RF_Ra_addr,
    output logic [3:0]       RF_Rb_addr,
    output logic             RF_W_en,
    output logic [ALU_W-1:0] ALU_s0,
    output logic             halted,
    output logic [3:0]       state_out
);

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_NOOP    = 4'd3,
        S_LOAD_W  = 4'd4,
        S_LOAD_WR = 4'd5,
        S_STORE   = 4'd6,
        S_ADD     = 4'd7,
        S_SUB     = 4'd8,
        S_HALT    = 4'd9,
        S_LDI     = 4'd10,
        S_JPZ     = 4'd11
    } state_t;

    localparam logic [3:0]       LOAD_LAST = 4'(LOAD_LAT - 1);
    localparam logic [ALU_W-1:0] ALU_ADD_C = ALU_W'(ALU_ADD);
    localparam logic [ALU_W-1:0] ALU_SUB_C = ALU_W'(ALU_SUB);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    logic [7:0] store_field;
    logic [7:0] load_field;
    assign store_field = IR[7:0];
    assign load_field  = IR[11:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    4'd1:    state_next = S_STORE;
                    4'd2:    state_next = S_LOAD_W;
                    4'd3:    state_next = S_ADD;
                    4'd4:    state_next = S_SUB;
                    4'd5:    state_next = S_HALT;
`ifdef CU_JUMP_EN
                    4'd6:    state_next = S_JPZ;
`endif
                    4'd7:    state_next = S_LDI;
                    default: state_next = S_NOOP;
                endcase
            end
            // Wait counter only ever runs inside LOAD_W; leaving the state leaves it at zero.
            S_LOAD_W: begin
                if (cnt_reg == LOAD_LAST) begin
                    state_next = S_LOAD_WR;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_HALT:   state_next = resume ? S_FETCH : S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        IR_ld      = 1'b0;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        PC_ld      = 1'b0;
        PC_addr    = 8'd0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 2'd0;
        RF_imm     = 8'd0;
        RF_W_addr  = 4'd0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        RF_W_en    = 1'b0;
        ALU_s0     = '0;
        halted     = 1'b0;
        case (state_reg)
            S_INIT: PC_clr = 1'b1;
            S_FETCH: begin
                PC_up = 1'b1;
                IR_ld = 1'b1;
            end
            S_STORE: begin
                D_addr     = store_field[D_AW-1:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
            end
            S_LOAD_W: begin
                D_addr    = load_field[D_AW-1:0];
                RF_s      = 2'd1;
                RF_W_addr = IR[3:0];
            end
            S_LOAD_WR: begin
                D_addr    = load_field[D_AW-1:0];
                RF_s      = 2'd1;
                RF_W_addr = IR[3:0];
                RF_W_en   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_reg == S_ADD) ? ALU_ADD_C : ALU_SUB_C;
            end
            S_LDI: begin
                RF_imm    = IR[11:4];
                RF_s      = 2'd2;
                RF_W_addr = IR[3:0];
                RF_W_en   = 1'b1;
            end
            S_HALT: halted = 1'b1;
`ifdef CU_JUMP_EN
            S_JPZ: begin
                RF_Ra_addr = IR[11:8];
                PC_addr    = IR[7:0];
                PC_ld      = RF_Rp_zero;
            end
`endif
            default: ;
        endcase
    end

`ifndef CU_JUMP_EN
    logic unused_rp_zero;
    assign unused_rp_zero = RF_Rp_zero;
`endif

    assign state_out = state_reg;

endmodule

// File: tb/tb_control_unit_p.sv
// Randomized self-checking bench for control_unit_p against an instruction-level expected-trace model.
module tb_control_unit_p;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic        resume = 1'b0;
    logic        RF_Rp_zero = 1'b0;
    logic        IR_ld, PC_clr, PC_up, PC_ld, D_wr, RF_W_en, halted;
    logic [7:0]  PC_addr, D_addr, RF_imm;
    logic [1:0]  RF_s;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_out;
    logic [2:0]  ALU_s0;

    control_unit_p #(.D_AW(8), .ALU_W(3), .ALU_ADD(1), .ALU_SUB(2), .LOAD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .IR(IR), .resume(resume), .RF_Rp_zero(RF_Rp_zero),
        .IR_ld(IR_ld), .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .PC_addr(PC_addr),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_imm(RF_imm), .RF_W_addr(RF_W_addr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .RF_W_en(RF_W_en), .ALU_s0(ALU_s0),
        .halted(halted), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_ld;
        logic       pc_clr;
        logic       pc_up;
        logic       pc_ld;
        logic [7:0] pc_addr;
        logic [7:0] d_addr;
        logic       d_wr;
        logic [1:0] rf_s;
        logic [7:0] rf_imm;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       we;
        logic [2:0] alu;
        logic       halted;
    } out_t;

    out_t obs;
    assign obs = {state_out, IR_ld, PC_clr, PC_up, PC_ld, PC_addr, D_addr, D_wr, RF_s, RF_imm,
                  RF_W_addr, RF_Ra_addr, RF_Rb_addr, RF_W_en, ALU_s0, halted};

    int   total = 0;
    int   bad = 0;
    out_t exp_q[$];
    logic rsm_q[$];

    function automatic out_t init_vec();
        out_t r = '0;
        r.pc_clr = 1'b1;
        return r;
    endfunction

    // Expected per-cycle trace of one instruction, starting at its FETCH cycle.
    task automatic build(input logic [15:0] ir, input logic zero, input int hw);
        out_t r;
        exp_q.delete();
        rsm_q.delete();
        r = '0; r.st = 4'd1; r.pc_up = 1'b1; r.ir_ld = 1'b1;
        exp_q.push_back(r); rsm_q.push_back(1'($urandom));
        r = '0; r.st = 4'd2;
        exp_q.push_back(r); rsm_q.push_back(1'($urandom));
        r = '0;
        case (ir[15:12])
            4'd1: begin
                r.st = 4'd6; r.d_addr = ir[7:0]; r.ra = ir[11:8]; r.d_wr = 1'b1;
                exp_q.push_back(r); rsm_q.push_back(1'($urandom));
            end
            4'd2: begin
                r.st = 4'd4; r.d_addr = ir[11:4]; r.rf_s = 2'd1; r.wa = ir[3:0];
                for (int k = 0; k < LAT; k++) begin
                    exp_q.push_back(r); rsm_q.push_back(1'($urandom));
                end
                r.st = 4'd5; r.we = 1'b1;
                exp_q.push_back(r); rsm_q.push_back(1'($urandom));
            end
            4'd3, 4'd4: begin
                r.st = (ir[15:12] == 4'd3) ? 4'd7 : 4'd8;
                r.ra = ir[11:8]; r.rb = ir[7:4]; r.wa = ir[3:0]; r.we = 1'b1;
                r.alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
                exp_q.push_back(r); rsm_q.push_back(1'($urandom));
            end
            4'd5: begin
                r.st = 4'd9; r.halted = 1'b1;
                for (int k = 0; k < hw; k++) begin
                    exp_q.push_back(r); rsm_q.push_back(1'b0);
                end
                exp_q.push_back(r); rsm_q.push_back(1'b1);
            end
`ifdef CU_JUMP_EN
            4'd6: begin
                r.st = 4'd11; r.ra = ir[11:8]; r.pc_addr = ir[7:0]; r.pc_ld = zero;
                exp_q.push_back(r); rsm_q.push_back(1'($urandom));
            end
`endif
            4'd7: begin
                r.st = 4'd10; r.rf_imm = ir[11:4]; r.rf_s = 2'd2; r.wa = ir[3:0]; r.we = 1'b1;
                exp_q.push_back(r); rsm_q.push_back(1'($urandom));
            end
            default: begin
                r.st = 4'd3;
                exp_q.push_back(r); rsm_q.push_back(1'($urandom));
            end
        endcase
    endtask

    // Entered and left 1 time unit after a rising edge, with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [15:0] ir, input logic zero, input int hw);
        build(ir, zero, hw);
        for (int i = 0; i < exp_q.size(); i++) begin
            IR = ir;
            RF_Rp_zero = zero;
            resume = rsm_q[i];
            #1;
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL %s ir=%h cyc%0d: got %h want %h", name, ir, i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        resume = 1'b0;
        $display("instr %s ir=%h zero=%0b cycles=%0d", name, ir, zero, exp_q.size());
    endtask

    task automatic check_now(input string name, input out_t want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, obs, want);
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] want);
        total++;
        if (state_out !== want) begin
            bad++;
            $display("FAIL %s: state got %0d want %0d", name, state_out, want);
        end
    endtask

    // Called with reset already low; holds it over one edge, releases, and lands in FETCH.
    task automatic reset_release(input string name);
        #1 check_now({name, "_async"}, init_vec());
        @(posedge clk); #1 check_now({name, "_held"}, init_vec());
        reset = 1'b1;
        #1 check_now({name, "_released"}, init_vec());
        @(posedge clk); #1 check_state({name, "_to_fetch"}, 4'd1);
        $display("reset %s done", name);
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        reset_release("reset");
    endtask

    task automatic test_basic();
        run_instr("noop", 16'h0000, 1'b0, 0);
        run_instr("store", 16'h1F29, 1'b0, 0);
        run_instr("load", 16'h20A7, 1'b0, 0);
        run_instr("add", 16'h3123, 1'b0, 0);
        run_instr("sub", 16'h4123, 1'b0, 0);
        run_instr("ldi", 16'h7C5E, 1'b0, 0);
        run_instr("op_f", 16'hF123, 1'b1, 0);
    endtask

    task automatic test_halt();
        run_instr("halt5", 16'h5000, 1'b0, 5);
        run_instr("halt0", 16'h5ABC, 1'b0, 0);
    endtask

    task automatic test_jump();
        run_instr("jpz_z1", 16'h6340, 1'b1, 0);
        run_instr("jpz_z0", 16'h6340, 1'b0, 0);
    endtask

    task automatic test_reset_mid_load();
        IR = 16'h20A7; resume = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 check_state("mid_load_in_load_w", 4'd4);
        #2 reset = 1'b0;
        reset_release("mid_load");
        run_instr("load_after_reset", 16'h20A7, 1'b0, 0);
    endtask

    task automatic test_reset_in_halt();
        IR = 16'h5000; resume = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 check_state("in_halt", 4'd9);
        #2 reset = 1'b0;
        reset_release("in_halt");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_instr("rand", 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_jump();
        test_reset_mid_load();
        test_reset_in_halt();
        test_random();
        run_instr("final_noop", 16'h8000, 1'b0, 0);
        check_state("final_fetch", 4'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_unit_p.md
CONTROL_UNIT_P -- requirements
Module: control_unit_p

Interface
REQ-001 SHALL take parameter D_AW, default 8, data-memory address width (1..8); D_addr = IR[D_AW-1:0] of the relevant field.
REQ-002 SHALL take parameter ALU_W, default 3, ALU select width.
REQ-003 SHALL take parameter ALU_ADD, default 1, ALU code driven for ADD.
REQ-004 SHALL take parameter ALU_SUB, default 2, ALU code driven for SUB.
REQ-005 SHALL take parameter LOAD_LAT, default 1, data-memory read wait cycles before register write (1..15).
REQ-006 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge;
 reset  in  1  asynchronous, active-low reset;
 IR  in  16  current instruction register contents;
 resume  in  1  leave HALT;
 RF_Rp_zero  in  1  register-file read port A equals zero;
 IR_ld  out  1  load instruction register;
 PC_clr  out  1  clear program counter;
 PC_up  out  1  increment program counter;
 PC_ld  out  1  load program counter from PC_addr;
 PC_addr  out  8  jump target;
 D_addr  out  D_AW  data-memory address;
 D_wr  out  1  data-memory write enable;
 RF_s  out  2  write-mux select: 0 ALU, 1 memory, 2 immediate;
 RF_imm  out  8  immediate value for RF_s=2;
 RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  4 each  register-file addresses;
 RF_W_en  out  1  register-file write enable;
 ALU_s0  out  ALU_W  ALU operation select;
 halted  out  1  high while in HALT;
 state_out  out  4  current state encoding.

Function
REQ-007 SHALL implement states INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_W=4, LOAD_WR=5, STORE=6, ADD=7, SUB=8, HALT=9, LDI=10, JPZ=11, driven on state_out.
REQ-008 SHALL drive all outputs combinationally from state and IR; every output defaults to 0 in every state unless stated otherwise.
REQ-009 INIT: PC_clr=1; next FETCH.
REQ-010 FETCH: PC_up=1, IR_ld=1; next DECODE.
REQ-011 DECODE on IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD_W, 3 ADD, 4 SUB, 5 HALT, 6 JPZ, 7 LDI, 8-15 NOOP.
REQ-012 NOOP: no outputs asserted; next FETCH.
REQ-013 STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1 for exactly one cycle; next FETCH.
REQ-014 LOAD_W: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]; a 4-bit wait counter counts up from 0, and the FSM moves to LOAD_WR when the counter equals LOAD_LAT-1; the counter clears on exit.
REQ-015 LOAD_WR: same outputs as LOAD_W plus RF_W_en=1 for one cycle; next FETCH; total LOAD latency from DECODE is LOAD_LAT+1 cycles.
REQ-016 ADD/SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_s=0, RF_W_en=1, ALU_s0=ALU_ADD or ALU_SUB, truncated to ALU_W; next FETCH.
REQ-017 LDI: RF_imm=IR[11:4], RF_s=2, RF_W_addr=IR[3:0], RF_W_en=1; next FETCH.
REQ-018 HALT: halted=1; stays in HALT while resume=0; resume=1 sampled at a clock edge moves to FETCH, with the PC not cleared.
REQ-019 resume SHALL be ignored in every state other than HALT.
REQ-020 No state SHALL assert D_wr and RF_W_en together.

Reset
REQ-021 reset=0 SHALL force INIT immediately (asynchronously) and clear the wait counter, from any state, including mid-LOAD_W and HALT.
REQ-022 While reset is low, outputs SHALL be: PC_clr=1, state_out=0, all others 0.
REQ-023 The first rising clk edge after reset deasserts SHALL move INIT to FETCH.

Configuration
REQ-024 With macro CU_JUMP_EN defined, JPZ drives RF_Ra_addr=IR[11:8] and PC_addr=IR[7:0]; it asserts PC_ld=1 only if RF_Rp_zero=1; next FETCH.
REQ-025 Without CU_JUMP_EN, opcode 6 SHALL decode to NOOP, PC_ld and PC_addr SHALL be tied to 0, and RF_Rp_zero SHALL be unused.

Verification
REQ-026 Reset, then IR=0x0000 -> state sequence 0,1,2,3,1; PC_clr=1 only in INIT.
REQ-027 IR=0x1F29 -> STORE cycle with D_wr=1, D_addr=0x29, RF_Ra_addr=15; D_wr is high for exactly one cycle.
REQ-028 LOAD_LAT=3, IR=0x20A7 -> three LOAD_W cycles with D_addr=0x0A, then one LOAD_WR cycle with RF_W_en=1 and RF_W_addr=7.
REQ-029 IR=0x3123 then IR=0x4123 -> ALU_s0=1, then ALU_s0=2; both with Ra=1, Rb=2, W=3, RF_W_en=1.
REQ-030 IR=0x5000 with resume=0 for 5 cycles -> halted=1 throughout; resume=1 -> FETCH next cycle; reset pulsed mid-LOAD_W -> INIT immediately without a clock edge.
REQ-031 CU_JUMP_EN defined, IR=0x6340, RF_Rp_zero=1 -> PC_ld=1, PC_addr=0x40; with RF_Rp_zero=0 -> PC_ld=0; macro undefined -> opcode 6 takes the NOOP path.
